framebuffer_swap_ctrl: RTL and testbench

//  Parametrised double-buffered framebuffer sitting between render_module (writer) and output_module (reader).

---
 rtl/framebuffer_swap_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_framebuffer_swap_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_swap_ctrl.sv
// -----------------------------------------------------------------------------
// framebuffer_swap_ctrl
//
// Double-buffered framebuffer between a renderer (writer) and a scan-out block
// (reader). The renderer fills the back bank while the scan-out reads the front
// bank. Banks swap only on a frame-start pulse once the renderer reports that
// the back bank is complete. After a swap the new back bank can optionally be
// filled with CLEAR_COLOR by hardware before the renderer is acknowledged.
// Counters report the number of swaps and the number of frames that had to be
// repeated because rendering was late.
//
// Ports
//   Clk           system clock
//   Reset_n       asynchronous active-low reset
//   new_frame     one-cycle frame-start pulse from the scan-out side
//   rd_x, rd_y    scan-out read coordinate
//   color_out     front-bank pixel at (rd_x, rd_y), one cycle after the request
//   wr_x, wr_y    render write coordinate
//   color_in      render write data
//   we            render write enable (back bank, RENDER state only)
//   render_done   level from renderer: back bank finished, held until ack
//   render_ack    one-cycle pulse: swap (and clear, if enabled) complete
//   busy          high in every state except RENDER
//   front_sel     index of the bank currently scanned out
//   swap_count    swaps since reset, wraps
//   repeat_count  late frames since reset, saturates at all-ones
// -----------------------------------------------------------------------------
module framebuffer_swap_ctrl #(
  parameter int                 H_RES       = 320,
  parameter int                 V_RES       = 240,
  parameter int                 COLOR_W     = 3,
  parameter int                 X_W         = 9,
  parameter int                 Y_W         = 8,
  parameter bit                 CLEAR_EN    = 1'b1,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               new_frame,
  input  logic [X_W-1:0]     rd_x,
  input  logic [Y_W-1:0]     rd_y,
  output logic [COLOR_W-1:0] color_out,
  input  logic [X_W-1:0]     wr_x,
  input  logic [Y_W-1:0]     wr_y,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               we,
  input  logic               render_done,
  output logic               render_ack,
  output logic               busy,
  output logic               front_sel,
  output logic [CNT_W-1:0]   swap_count,
  output logic [CNT_W-1:0]   repeat_count
);

  localparam int DEPTH  = H_RES * V_RES;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // y*H_RES + x fits in X_W+Y_W+1 bits because H_RES <= 2**X_W.
  localparam int FULL_W = X_W + Y_W + 1;

  typedef enum logic [2:0] {
    S_RENDER,
    S_WAIT_VB,
    S_CLEAR,
    S_ACK,
    S_REL
  } state_t;

  state_t           state_reg, state_next;
  logic             front_sel_reg, front_sel_next;
  logic [CNT_W-1:0] swap_count_reg, swap_count_next;
  logic [CNT_W-1:0] repeat_count_reg, repeat_count_next;
  logic [AW-1:0]    clear_addr_reg, clear_addr_next;
  logic             do_swap;

  // Linear pixel address, computed at full width before being narrowed to
  // the RAM address, so out-of-range coordinates cannot alias silently.
  function automatic logic [FULL_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    lin_addr = FULL_W'(y) * FULL_W'(H_RES) + FULL_W'(x);
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          rd_in_range, wr_in_range;
  logic [AW-1:0] rd_addr, wr_addr;

  assign rd_in_range = (int'(rd_x) < H_RES) && (int'(rd_y) < V_RES);
  assign wr_in_range = (int'(wr_x) < H_RES) && (int'(wr_y) < V_RES);
  assign rd_addr     = rd_in_range ? AW'(lin_addr(rd_x, rd_y)) : '0;
  assign wr_addr     = wr_in_range ? AW'(lin_addr(wr_x, wr_y)) : '0;

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg        <= S_RENDER;
      front_sel_reg    <= 1'b0;
      swap_count_reg   <= '0;
      repeat_count_reg <= '0;
      clear_addr_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      front_sel_reg    <= front_sel_next;
      swap_count_reg   <= swap_count_next;
      repeat_count_reg <= repeat_count_next;
      clear_addr_reg   <= clear_addr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    front_sel_next    = front_sel_reg;
    swap_count_next   = swap_count_reg;
    repeat_count_next = repeat_count_reg;
    clear_addr_next   = clear_addr_reg;
    do_swap           = 1'b0;

    case (state_reg)
      S_RENDER: begin
        if (render_done && new_frame) begin
          do_swap = 1'b1;
        end else if (render_done) begin
          state_next = S_WAIT_VB;
        end else if (new_frame && (repeat_count_reg != '1)) begin
          // Frame started with nothing new: scan-out repeats the old frame.
          repeat_count_next = repeat_count_reg + CNT_W'(1);
        end
      end
      S_WAIT_VB: begin
        if (new_frame) begin
          do_swap = 1'b1;
        end
      end
      S_CLEAR: begin
        // Frame starts are ignored here; the renderer has not been released.
        if (clear_addr_reg == AW'(DEPTH - 1)) begin
          clear_addr_next = '0;
          state_next      = S_ACK;
        end else begin
          clear_addr_next = clear_addr_reg + AW'(1);
        end
      end
      S_ACK: begin
        state_next = S_REL;
      end
      S_REL: begin
        // Wait for the renderer to drop its request so one done = one swap.
        if (!render_done) begin
          state_next = S_RENDER;
        end
      end
      default: begin
        state_next = S_RENDER;
      end
    endcase

    if (do_swap) begin
      front_sel_next  = ~front_sel_reg;
      swap_count_next = swap_count_reg + CNT_W'(1);
      clear_addr_next = '0;
      if (CLEAR_EN) begin
        state_next = S_CLEAR;
      end else begin
        state_next = S_ACK;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Back-bank write port. The clear engine and the renderer are never active
  // in the same state, so a simple priority mux is enough.
  // ---------------------------------------------------------------------------
  logic               back_we;
  logic [AW-1:0]      back_addr;
  logic [COLOR_W-1:0] back_data;

  always_comb begin
    back_we   = 1'b0;
    back_addr = wr_addr;
    back_data = color_in;
    if (state_reg == S_CLEAR) begin
      back_we   = 1'b1;
      back_addr = clear_addr_reg;
      back_data = CLEAR_COLOR;
    end else if ((state_reg == S_RENDER) && we && wr_in_range) begin
      back_we = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Two banks: one write port (active only while this bank is the back bank)
  // and one registered read port each. Both banks are read every cycle and the
  // front one is picked afterwards, which keeps each RAM a plain simple
  // dual-port block.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : gen_bank
    localparam logic BANK_ID = 1'(gi);

    logic [COLOR_W-1:0] mem [DEPTH];
    logic [COLOR_W-1:0] rd_data_reg;
    logic               bank_we;

    assign bank_we = back_we && (front_sel_reg != BANK_ID);

    always_ff @(posedge Clk) begin
      if (bank_we) begin
        mem[back_addr] <= back_data;
      end
      rd_data_reg <= mem[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Read-side pipeline. The bank select is captured together with the read,
  // so a read sampled on the swap edge still returns the old front bank.
  // The RAM output registers carry no reset; rd_valid_reg forces color_out
  // to zero from reset until the first real read has been captured.
  // ---------------------------------------------------------------------------
  logic rd_sel_reg;
  logic rd_oob_reg;
  logic rd_valid_reg;

  always_ff @(posedge Clk) begin
    rd_sel_reg <= front_sel_reg;
    rd_oob_reg <= !rd_in_range;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b1;
    end
  end

  always_comb begin
    color_out = '0;
    if (rd_valid_reg) begin
      if (rd_oob_reg) begin
        color_out = CLEAR_COLOR;
      end else if (rd_sel_reg) begin
        color_out = gen_bank[1].rd_data_reg;
      end else begin
        color_out = gen_bank[0].rd_data_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign render_ack   = (state_reg == S_ACK);
  assign busy         = (state_reg != S_RENDER);
  assign front_sel    = front_sel_reg;
  assign swap_count   = swap_count_reg;
  assign repeat_count = repeat_count_reg;

endmodule

// File: tb/tb_framebuffer_swap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_swap_ctrl
//
// Two instances share one stimulus stream:
//   i0: 4x2 bank, clear enabled (fill 3'b010), 2-bit counters
//   i1: 8x8 bank, clear disabled (out-of-range colour 3'b110), 16-bit counters
// A frame-level reference model (bank arrays, phase, counters) predicts every
// output after every clock edge; directed sequences add fixed expectations.
// -----------------------------------------------------------------------------
module tb_framebuffer_swap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        new_frame;
  logic [3:0]  rd_x, rd_y, wr_x, wr_y;
  logic [2:0]  color_in;
  logic        we;
  logic        render_done;

  logic [2:0]  color_out0, color_out1;
  logic        render_ack0, render_ack1;
  logic        busy0, busy1;
  logic        front_sel0, front_sel1;
  logic [1:0]  swap_count0, repeat_count0;
  logic [15:0] swap_count1, repeat_count1;

  framebuffer_swap_ctrl #(
    .H_RES(4), .V_RES(2), .COLOR_W(3), .X_W(3), .Y_W(2),
    .CLEAR_EN(1'b1), .CLEAR_COLOR(3'b010), .CNT_W(2)
  ) dut0 (
    .Clk(clk), .Reset_n(rst_n), .new_frame(new_frame),
    .rd_x(rd_x[2:0]), .rd_y(rd_y[1:0]), .color_out(color_out0),
    .wr_x(wr_x[2:0]), .wr_y(wr_y[1:0]), .color_in(color_in), .we(we),
    .render_done(render_done), .render_ack(render_ack0), .busy(busy0),
    .front_sel(front_sel0), .swap_count(swap_count0), .repeat_count(repeat_count0)
  );

  framebuffer_swap_ctrl #(
    .H_RES(8), .V_RES(8), .COLOR_W(3), .X_W(4), .Y_W(4),
    .CLEAR_EN(1'b0), .CLEAR_COLOR(3'b110), .CNT_W(16)
  ) dut1 (
    .Clk(clk), .Reset_n(rst_n), .new_frame(new_frame),
    .rd_x(rd_x), .rd_y(rd_y), .color_out(color_out1),
    .wr_x(wr_x), .wr_y(wr_y), .color_in(color_in), .we(we),
    .render_done(render_done), .render_ack(render_ack1), .busy(busy1),
    .front_sel(front_sel1), .swap_count(swap_count1), .repeat_count(repeat_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  localparam int PH_RENDER = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_CLEAR  = 2;
  localparam int PH_ACK    = 3;
  localparam int PH_REL    = 4;

  int m_hr[2]    = '{4, 8};
  int m_vr[2]    = '{2, 8};
  int m_xmask[2] = '{7, 15};
  int m_ymask[2] = '{3, 15};
  bit m_clren[2] = '{1'b1, 1'b0};
  int m_clr[2]   = '{2, 6};
  int m_cmax[2]  = '{3, 65535};

  int         m_phase[2];
  int         m_front[2];
  int         m_clear_left[2];
  int         m_swaps[2];
  int         m_repeats[2];
  int         m_color[2];
  bit         m_color_known[2];
  logic [2:0] m_mem[2][2][64];
  bit         m_known[2][2][64];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      // A reset during the clear leaves that bank only partly cleared.
      if (m_phase[i] == PH_CLEAR) begin
        for (int a = 0; a < 64; a++) m_known[i][1 - m_front[i]][a] = 1'b0;
      end
      m_phase[i]       = PH_RENDER;
      m_front[i]       = 0;
      m_clear_left[i]  = 0;
      m_swaps[i]       = 0;
      m_repeats[i]     = 0;
      m_color[i]       = 0;
      m_color_known[i] = 1'b1;
    end
  endtask

  task automatic model_edge(input int i);
    int rx, ry, wx, wy, dep, back;
    bit swap;
    dep = m_hr[i] * m_vr[i];
    rx  = int'(rd_x) & m_xmask[i];
    ry  = int'(rd_y) & m_ymask[i];
    wx  = int'(wr_x) & m_xmask[i];
    wy  = int'(wr_y) & m_ymask[i];

    // read of the front bank as it is before this edge
    if (rx >= m_hr[i] || ry >= m_vr[i]) begin
      m_color[i]       = m_clr[i];
      m_color_known[i] = 1'b1;
    end else begin
      m_color[i]       = int'(m_mem[i][m_front[i]][ry * m_hr[i] + rx]);
      m_color_known[i] = m_known[i][m_front[i]][ry * m_hr[i] + rx];
    end

    back = 1 - m_front[i];
    if (m_phase[i] == PH_RENDER && we && wx < m_hr[i] && wy < m_vr[i]) begin
      m_mem[i][back][wy * m_hr[i] + wx]   = color_in;
      m_known[i][back][wy * m_hr[i] + wx] = 1'b1;
    end

    swap = 1'b0;
    case (m_phase[i])
      PH_RENDER: begin
        if (render_done && new_frame) swap = 1'b1;
        else if (render_done) m_phase[i] = PH_WAIT;
        else if (new_frame && m_repeats[i] < m_cmax[i]) m_repeats[i]++;
      end
      PH_WAIT:  if (new_frame) swap = 1'b1;
      PH_CLEAR: begin
        m_clear_left[i]--;
        if (m_clear_left[i] == 0) m_phase[i] = PH_ACK;
      end
      PH_ACK:   m_phase[i] = PH_REL;
      default:  if (!render_done) m_phase[i] = PH_RENDER;
    endcase

    if (swap) begin
      m_front[i] = back;
      m_swaps[i] = (m_swaps[i] + 1) % (m_cmax[i] + 1);
      if (m_clren[i]) begin
        // The new back bank cannot be read before the clear has finished,
        // so filling it at once is observably equivalent.
        for (int a = 0; a < dep; a++) begin
          m_mem[i][1 - m_front[i]][a]   = 3'(m_clr[i]);
          m_known[i][1 - m_front[i]][a] = 1'b1;
        end
        m_clear_left[i] = dep;
        m_phase[i]      = PH_CLEAR;
      end else begin
        m_phase[i] = PH_ACK;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [2:0] col, input logic ack,
                            input logic bsy, input logic fs,
                            input logic [15:0] sc, input logic [15:0] rc);
    if (m_color_known[i]) chk($sformatf("i%0d_color", i), 32'(col), 32'(m_color[i]));
    chk($sformatf("i%0d_ack", i),     32'(ack), 32'(m_phase[i] == PH_ACK));
    chk($sformatf("i%0d_busy", i),    32'(bsy), 32'(m_phase[i] != PH_RENDER));
    chk($sformatf("i%0d_front", i),   32'(fs),  32'(m_front[i]));
    chk($sformatf("i%0d_swaps", i),   32'(sc),  32'(m_swaps[i]));
    chk($sformatf("i%0d_repeats", i), 32'(rc),  32'(m_repeats[i]));
  endtask

  task automatic check_all();
    check_inst(0, color_out0, render_ack0, busy0, front_sel0,
               16'(swap_count0), 16'(repeat_count0));
    check_inst(1, color_out1, render_ack1, busy1, front_sel1,
               swap_count1, repeat_count1);
  endtask

  // One clock: inputs were set after the previous edge; advance model, check.
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    new_frame   = 1'b0;
    we          = 1'b0;
    render_done = 1'b0;
    rd_x = '0; rd_y = '0; wr_x = '0; wr_y = '0; color_in = '0;
  endtask

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      new_frame = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) render_done = ~render_done;
      we       = 1'($urandom);
      wr_x     = 4'($urandom_range(0, 9));
      wr_y     = 4'($urandom_range(0, 9));
      rd_x     = 4'($urandom_range(0, 9));
      rd_y     = 4'($urandom_range(0, 9));
      color_in = 3'($urandom);
      tick();
    end
    $display("random block: %0d cycles, checks so far %0d", n, n_total);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = PH_RENDER;
      m_front[i] = 0;
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 64; a++) m_known[i][b][a] = 1'b0;
    end

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst_n = 1'b1;
    $display("reset: outputs checked");

    // Late frames: repeat counter, saturation on the 2-bit instance
    for (int k = 0; k < 5; k++) begin
      new_frame = 1'b1; tick();
      new_frame = 1'b0; tick();
      if (k == 2) begin
        chk("t4_rep3", 32'(repeat_count1), 32'd3);
        chk("t4_front_kept", 32'(front_sel1), 32'd0);
      end
    end
    chk("t4_sat", 32'(repeat_count0), 32'd3);
    chk("t4_rep5", 32'(repeat_count1), 32'd5);
    $display("late frames: rep0=%0d rep1=%0d", repeat_count0, repeat_count1);

    // Write, simultaneous done+frame swap, read back; clear latency on i0
    wr_x = 4'd5; wr_y = 4'd7; color_in = 3'b101; we = 1'b1;
    tick();
    we = 1'b0;
    render_done = 1'b1; new_frame = 1'b1; rd_x = 4'd5; rd_y = 4'd7;
    tick();
    chk("t2_ack_after_swap", 32'(render_ack1), 32'd1);
    chk("t2_swap_count", 32'(swap_count1), 32'd1);
    new_frame = 1'b0;
    tick();
    chk("t2_read", 32'(color_out1), 32'b101);
    chk("t2_ack_single", 32'(render_ack1), 32'd0);
    n = 3;
    while (n <= 20) begin
      tick();
      if (render_ack0) break;
      n++;
    end
    chk("t3_ack_latency", 32'(n), 32'd9);
    $display("swap: read=%0b clear latency=%0d", color_out1, n);

    // render_done held after ack: stay released, no second swap
    for (int k = 0; k < 3; k++) begin
      new_frame = 1'b1; tick();
      new_frame = 1'b0; tick();
    end
    chk("t5_busy1", 32'(busy1), 32'd1);
    chk("t5_busy0", 32'(busy0), 32'd1);
    chk("t5_no_swap1", 32'(swap_count1), 32'd1);
    chk("t5_no_swap0", 32'(swap_count0), 32'd1);
    render_done = 1'b0;
    tick(); tick();
    chk("t5_idle", 32'(busy1), 32'd0);
    $display("hold: released after render_done dropped");

    // Clear: fill i0 back bank with 3'b111, then writes during WAIT_VB/CLEAR
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        wr_x = 4'(x); wr_y = 4'(y); color_in = 3'b111; we = 1'b1;
        tick();
      end
    end
    render_done = 1'b1; we = 1'b0;
    tick();
    wr_x = 4'd1; wr_y = 4'd0; color_in = 3'b001; we = 1'b1;
    tick(); tick();
    new_frame = 1'b1;
    we = 1'b0;
    tick();
    new_frame = 1'b0;
    for (int k = 0; k < 20 && !render_ack0; k++) begin
      we = 1'b1; wr_x = 4'($urandom_range(0, 3)); wr_y = 4'($urandom_range(0, 1));
      color_in = 3'b101;
      tick();
    end
    we = 1'b0; render_done = 1'b0;
    rd_x = 4'd1; rd_y = 4'd0;
    tick(); tick();
    chk("t6_waitvb_ignored", 32'(color_out0), 32'b111);
    render_done = 1'b1; new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        rd_x = 4'(x); rd_y = 4'(y);
        tick();
        chk($sformatf("t3_cleared_%0d_%0d", x, y), 32'(color_out0), 32'b010);
      end
    end
    render_done = 1'b0;
    repeat (12) tick();
    $display("clear: cleared bank read back");

    // Bounds: out-of-range write must not alias, out-of-range read
    we = 1'b1; wr_x = 4'd0; wr_y = 4'd1; color_in = 3'b100;
    tick();
    wr_x = 4'd8; wr_y = 4'd0; color_in = 3'b011;
    tick();
    we = 1'b0; render_done = 1'b1; new_frame = 1'b1;
    tick();
    new_frame = 1'b0; rd_x = 4'd0; rd_y = 4'd1;
    tick();
    chk("t6_no_alias", 32'(color_out1), 32'b100);
    rd_x = 4'd8; rd_y = 4'd0;
    tick();
    chk("t6_oob_read1", 32'(color_out1), 32'b110);
    rd_x = 4'd4;
    tick();
    chk("t6_oob_read0", 32'(color_out0), 32'b010);
    render_done = 1'b0;
    repeat (12) tick();
    $display("bounds: oob read/write checked");

    // Randomized traffic, asynchronous reset mid-run, more traffic
    random_cycles(1200);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t1_async_front", 32'(front_sel0), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t1_render_state", 32'(busy1), 32'd0);
    $display("async reset: outputs cleared mid-run");
    random_cycles(800);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
